// File: rtl/sha_1_block_sched.sv
// ----------------------------------------------------------------------------
// sha_1_block_sched
//
// Multi-block message sequencer in front of a SHA-1 compression core.
// Collects a pre-padded message as 32-bit words and groups them into
// 16-word blocks. It launches one compression per block and chains the five
// state words across blocks with the feed-forward add. It then holds the
// final 160-bit digest until the consumer acknowledges it.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent waiting for core_done before error
//   CNT_W           width of block_count
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   msg_word      message word (big-endian SHA-1 word order)
//   msg_valid     msg_word is valid
//   msg_ready     a word is accepted this cycle (FILL only)
//   msg_last      final word of the final block, legal only on word 15
//   abort         synchronous abort, overrides every other event
//   core_start    one-cycle launch pulse to the core
//   core_block    16 block words to the core, [0] = first word received
//   core_chain    chaining input a..e to the core
//   core_digest   core result a..e before feed-forward
//   core_done     one-cycle completion pulse from the core
//   digest        final hash H0..H4
//   digest_valid  digest is valid, held until digest_ack
//   digest_ack    consumer accepts the digest
//   busy          a message is in progress
//   error         sticky error flag, cleared only by abort or reset
//   block_count   blocks completed in the current message (saturating)
// ----------------------------------------------------------------------------
module sha_1_block_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           msg_word,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic                  msg_last,
  input  logic                  abort,
  output logic                  core_start,
  output logic [15:0][31:0]     core_block,
  output logic [4:0][31:0]      core_chain,
  input  logic [4:0][31:0]      core_digest,
  input  logic                  core_done,
  output logic [4:0][31:0]      digest,
  output logic                  digest_valid,
  input  logic                  digest_ack,
  output logic                  busy,
  output logic                  error,
  output logic [CNT_W-1:0]      block_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  // SHA-1 initial hash values, [0] = H0 (a).
  localparam logic [4:0][31:0] H_INIT = {32'hC3D2E1F0, 32'h10325476,
                                         32'h98BADCFE, 32'hEFCDAB89,
                                         32'h67452301};

  typedef enum logic [2:0] {
    S_FILL,
    S_LAUNCH,
    S_WAIT,
    S_ACCUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          word_cnt;
  logic [TMR_W-1:0]    timer;
  logic                last_flag;
  logic [4:0][31:0]    chain;
  logic [4:0][31:0]    digest_reg;
  logic [4:0][31:0]    chain_sum;
  logic                last_bad;

  // Block counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Feed-forward add: five independent modulo-2^32 sums, no carry between words.
  function automatic logic [4:0][31:0] feed_fwd(input logic [4:0][31:0] a,
                                                input logic [4:0][31:0] b);
    logic [4:0][31:0] r;
    for (int i = 0; i < 5; i++) r[i] = a[i] + b[i];
    return r;
  endfunction

  // msg_last is only meaningful on the 16th word; elsewhere the word is dropped.
  assign last_bad  = msg_last && (word_cnt != 4'd15);
  assign chain_sum = feed_fwd(chain, digest_reg);

  assign core_chain   = chain;
  assign msg_ready    = (state == S_FILL);
  assign core_start   = (state == S_LAUNCH);
  assign digest_valid = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign busy         = (state != S_FILL) || (word_cnt != 4'd0) || (block_count != '0);

  // ---- state register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FILL;
    else          state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (msg_valid) begin
          if (last_bad)                  state_nxt = S_ERR;
          else if (word_cnt == 4'd15)    state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        // A completion in the final timer cycle still wins over the timeout.
        if (core_done)                                   state_nxt = S_ACCUM;
        else if (timer == TMR_W'(TIMEOUT_CYCLES - 1))    state_nxt = S_ERR;
      end
      S_ACCUM:  state_nxt = last_flag ? S_DONE : S_FILL;
      S_DONE:   if (digest_ack) state_nxt = S_FILL;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_FILL;
    endcase
    if (abort) state_nxt = S_FILL;
  end

  // ---- block assembly, core result capture and chaining ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt    <= '0;
      block_count <= '0;
      timer       <= '0;
      last_flag   <= 1'b0;
      chain       <= H_INIT;
      digest      <= '0;
      digest_reg  <= '0;
      core_block  <= '0;
    end else if (abort) begin
      word_cnt    <= '0;
      block_count <= '0;
      timer       <= '0;
      last_flag   <= 1'b0;
      chain       <= H_INIT;
    end else begin
      case (state)
        S_FILL: begin
          if (msg_valid && !last_bad) begin
            core_block[word_cnt] <= msg_word;
            word_cnt             <= word_cnt + 4'd1;
            if (word_cnt == 4'd15) last_flag <= msg_last;
          end
        end
        S_LAUNCH: timer <= '0;
        S_WAIT: begin
          if (core_done) digest_reg <= core_digest;
          else           timer      <= timer + 1'b1;
        end
        S_ACCUM: begin
          chain       <= chain_sum;
          block_count <= sat_inc(block_count);
          word_cnt    <= '0;
          if (last_flag) digest <= chain_sum;
        end
        S_DONE: begin
          if (digest_ack) begin
            chain       <= H_INIT;
            block_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_1_block_sched.sv
// ----------------------------------------------------------------------------
// tb_sha_1_block_sched
//
// Bench for sha_1_block_sched. The bench plays the message source, the SHA-1
// core and the digest consumer. Expected digests come from a plain SHA-1
// model computed over the message words, and from the well-known digests of
// "abc" and the 56-byte two-block string.
// ----------------------------------------------------------------------------
module tb_sha_1_block_sched;

  localparam int TMO = 255;
  localparam int CW  = 16;

  typedef logic [4:0][31:0]  st_t;
  typedef logic [15:0][31:0] blk_t;

  localparam st_t H0  = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                         32'hEFCDAB89, 32'h67452301};
  localparam st_t ABC = {32'h9CD0D89D, 32'h7850C26C, 32'hBA3E2571,
                         32'h4706816A, 32'hA9993E36};
  localparam st_t TWO = {32'hE54670F1, 32'hF95129E5, 32'hBAAE4AA1,
                         32'h1C3BD26E, 32'h84983E44};

  logic            clk;
  logic            reset_n;
  logic [31:0]     msg_word;
  logic            msg_valid;
  logic            msg_ready;
  logic            msg_last;
  logic            abort;
  logic            core_start;
  blk_t            core_block;
  st_t             core_chain;
  st_t             core_digest;
  logic            core_done;
  st_t             digest;
  logic            digest_valid;
  logic            digest_ack;
  logic            busy;
  logic            error;
  logic [CW-1:0]   block_count;

  int tests = 0;
  int fails = 0;
  logic [31:0] msg[$];

  sha_1_block_sched #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .msg_word(msg_word), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_last(msg_last), .abort(abort),
    .core_start(core_start), .core_block(core_block), .core_chain(core_chain),
    .core_digest(core_digest), .core_done(core_done),
    .digest(digest), .digest_valid(digest_valid), .digest_ack(digest_ack),
    .busy(busy), .error(error), .block_count(block_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- reference SHA-1 ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic st_t compress(input st_t h, input blk_t blk);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
      t = rol(a, 5) + f + e + k + w[i];
      e = d; d = c; c = rol(b, 30); b = a; a = t;
    end
    return {e, d, c, b, a};
  endfunction

  function automatic st_t ffwd(input st_t x, input st_t y);
    st_t r;
    for (int i = 0; i < 5; i++) r[i] = x[i] + y[i];
    return r;
  endfunction

  function automatic blk_t get_blk(input int k);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = msg[16*k+i];
    return b;
  endfunction

  // ---------------- checkers ----------------
  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input st_t obs, input st_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_k(input string tag, input blk_t obs, input blk_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_abc();
    msg.delete();
    msg.push_back(32'h61626380);
    for (int i = 1; i < 15; i++) msg.push_back(32'h0);
    msg.push_back(32'h00000018);
  endtask

  task automatic load_two();
    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
            32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
            32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
    for (int i = 0; i < 15; i++) msg.push_back(32'h0);
    msg.push_back(32'h000001C0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input int gap);
    int n;
    for (int g = 0; g < gap; g++) tick();
    n = 0;
    while (msg_ready !== 1'b1 && n < 100) begin tick(); n++; end
    chk_b("msg_ready_wait", msg_ready, 1'b1);
    msg_valid = 1'b1; msg_word = w; msg_last = last;
    tick();
    msg_valid = 1'b0; msg_last = 1'b0; msg_word = $urandom();
  endtask

  task automatic send_block(input int k, input int gap_max, input logic final_blk);
    for (int i = 0; i < 16; i++)
      send_word(msg[16*k+i], final_blk && (i == 15),
                (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
  endtask

  // Acts as the compression core; entered in the LAUNCH cycle and returns
  // two cycles after the core_done edge.
  task automatic serve_core(input int delay, input st_t exp_chain, input blk_t exp_blk,
                            input logic final_blk);
    st_t res;
    chk_b("core_start_rise", core_start, 1'b1);
    chk_s("core_chain", core_chain, exp_chain);
    chk_k("core_block", core_block, exp_blk);
    res = compress(core_chain, core_block);
    tick();
    chk_b("core_start_pulse", core_start, 1'b0);
    for (int i = 0; i < delay; i++) begin
      chk_b("wait_ready_low", msg_ready, 1'b0);
      chk_s("wait_chain_hold", core_chain, exp_chain);
      chk_k("wait_block_hold", core_block, exp_blk);
      tick();
    end
    chk_b("wait_ready_low", msg_ready, 1'b0);
    core_done = 1'b1; core_digest = res;
    tick();
    core_done = 1'b0;
    core_digest = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    chk_b("accum_ready_low", msg_ready, 1'b0);
    chk_b("accum_valid_low", digest_valid, 1'b0);
    tick();
    if (final_blk) begin
      chk_b("done_valid", digest_valid, 1'b1);
      chk_b("done_ready_low", msg_ready, 1'b0);
    end else begin
      chk_b("next_block_ready", msg_ready, 1'b1);
      chk_b("next_block_valid", digest_valid, 1'b0);
    end
  endtask

  task automatic send_msg(input int delay_max, input int gap_max, output st_t dig);
    int   nb;
    st_t  ch;
    blk_t b;
    nb = msg.size() / 16;
    ch = H0;
    for (int k = 0; k < nb; k++) begin
      b = get_blk(k);
      send_block(k, gap_max, k == nb - 1);
      serve_core(int'($urandom_range(0, delay_max)), ch, b, k == nb - 1);
      ch = ffwd(ch, compress(ch, b));
      chk_n("block_count_step", 32'(block_count), k + 1);
    end
    dig = ch;
  endtask

  task automatic ack_digest(input int hold, input st_t exp);
    for (int i = 0; i < hold; i++) begin
      chk_b("hold_valid", digest_valid, 1'b1);
      chk_s("hold_digest", digest, exp);
      tick();
    end
    chk_b("pre_ack_valid", digest_valid, 1'b1);
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    chk_b("ack_valid_drop", digest_valid, 1'b0);
    chk_n("ack_block_count", 32'(block_count), 0);
    chk_s("ack_chain_reinit", core_chain, H0);
    chk_b("ack_ready", msg_ready, 1'b1);
    chk_b("ack_busy", busy, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    st_t  dig, ch1;
    blk_t b;
    int   n;
    logic seen;

    reset_n = 1'b0; msg_word = '0; msg_valid = 1'b0; msg_last = 1'b0;
    abort = 1'b0; core_digest = '0; core_done = 1'b0; digest_ack = 1'b0;
    tick(); tick();

    chk_b("rst_ready", msg_ready, 1'b1);
    chk_b("rst_core_start", core_start, 1'b0);
    chk_b("rst_valid", digest_valid, 1'b0);
    chk_b("rst_error", error, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_n("rst_block_count", 32'(block_count), 0);
    chk_s("rst_digest", digest, '0);
    chk_s("rst_chain", core_chain, H0);
    chk_k("rst_block", core_block, '0);
    reset_n = 1'b1;
    tick();

    // "abc", single block
    load_abc();
    send_msg(3, 0, dig);
    chk_s("abc_model", dig, ABC);
    chk_s("abc_digest", digest, ABC);
    chk_n("abc_count", 32'(block_count), 1);
    ack_digest(0, ABC);

    // two-block message
    load_two();
    send_msg(4, 1, dig);
    chk_s("two_digest", digest, TWO);
    chk_n("two_count", 32'(block_count), 2);
    ack_digest(1, TWO);

    // core never answers: timeout
    load_abc();
    send_block(0, 0, 1'b1);
    chk_b("to_start", core_start, 1'b1);
    n = 0; seen = 1'b0;
    while (error !== 1'b1 && n < 2 * TMO) begin
      tick(); n++;
      seen = seen | msg_ready;
    end
    chk_n("timeout_cycles", n, TMO + 1);
    chk_b("timeout_ready_seen", seen, 1'b0);
    core_done = 1'b1; core_digest = ABC;
    tick();
    core_done = 1'b0;
    tick(); tick();
    chk_b("err_sticky", error, 1'b1);
    chk_b("err_ready", msg_ready, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_b("abort_error_clr", error, 1'b0);
    chk_b("abort_ready", msg_ready, 1'b1);
    chk_s("abort_chain", core_chain, H0);
    chk_b("abort_busy", busy, 1'b0);

    // msg_last on word 7
    load_abc();
    for (int i = 0; i < 7; i++) send_word(msg[i], 1'b0, 0);
    send_word(32'hDEADBEEF, 1'b1, 0);
    chk_b("early_last_error", error, 1'b1);
    chk_b("early_last_ready", msg_ready, 1'b0);
    chk_n("early_last_discard", core_block[7], 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin seen = seen | core_start; tick(); end
    chk_b("early_last_no_start", seen, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_b("early_abort_error", error, 1'b0);
    send_msg(2, 0, dig);
    chk_s("after_err_abc", digest, ABC);
    ack_digest(0, ABC);

    // delayed ack, then a fresh message
    load_abc();
    send_msg(5, 0, dig);
    chk_s("slow_ack_digest", digest, ABC);
    ack_digest(10, ABC);
    send_msg(1, 2, dig);
    chk_s("post_ack_abc", digest, ABC);
    ack_digest(0, ABC);

    // abort together with core_done in the second block's WAIT
    load_two();
    b = get_blk(0);
    send_block(0, 0, 1'b0);
    serve_core(3, H0, b, 1'b0);
    chk_n("abort_pre_count", 32'(block_count), 1);
    ch1 = ffwd(H0, compress(H0, b));
    send_block(1, 0, 1'b1);
    chk_b("abort_launch", core_start, 1'b1);
    chk_s("second_chain", core_chain, ch1);
    tick(); tick(); tick();
    core_done = 1'b1; core_digest = compress(ch1, get_blk(1)); abort = 1'b1;
    tick();
    core_done = 1'b0; abort = 1'b0;
    chk_b("abort_done_ready", msg_ready, 1'b1);
    chk_n("abort_done_count", 32'(block_count), 0);
    chk_b("abort_done_busy", busy, 1'b0);
    chk_s("abort_done_chain", core_chain, H0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin seen = seen | digest_valid | core_start; tick(); end
    chk_b("abort_done_quiet", seen, 1'b0);
    core_done = 1'b1; core_digest = ABC;
    tick();
    core_done = 1'b0;
    tick();
    chk_b("stray_done_ready", msg_ready, 1'b1);
    chk_b("stray_done_busy", busy, 1'b0);
    chk_s("stray_done_chain", core_chain, H0);

    // asynchronous reset in the middle of FILL (word 9 of block 2)
    load_two();
    b = get_blk(0);
    send_block(0, 0, 1'b0);
    serve_core(2, H0, b, 1'b0);
    for (int i = 0; i < 9; i++) send_word(msg[16+i], 1'b0, 0);
    msg_valid = 1'b1; msg_word = msg[25];
    #2 reset_n = 1'b0;
    #1;
    chk_b("arst_ready", msg_ready, 1'b1);
    chk_b("arst_core_start", core_start, 1'b0);
    chk_b("arst_valid", digest_valid, 1'b0);
    chk_b("arst_error", error, 1'b0);
    chk_b("arst_busy", busy, 1'b0);
    chk_n("arst_count", 32'(block_count), 0);
    chk_s("arst_digest", digest, '0);
    chk_s("arst_chain", core_chain, H0);
    chk_k("arst_block", core_block, '0);
    msg_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // random multi-block messages against the reference model
    for (int r = 0; r < 6; r++) begin
      int nb;
      nb = int'($urandom_range(1, 3));
      msg.delete();
      for (int i = 0; i < 16 * nb; i++) msg.push_back($urandom());
      send_msg(8, 2, dig);
      chk_s("rand_digest", digest, dig);
      chk_n("rand_count", 32'(block_count), nb);
      ack_digest(int'($urandom_range(0, 3)), dig);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
